// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN front-end frame sequencer: sequencer FSM
// states, pixel width and the fixed lengths of the CLEAR and DRAIN phases.
package cnn_pkg;

  localparam int PIX_W        = 8;
  localparam int CLEAR_CYCLES = 2;
  localparam int DRAIN_CYCLES = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } seq_state_e;

  // Number of complete 3x3 windows that fit inside a w x h frame.
  function automatic logic [15:0] expected_windows(input int w, input int h);
    return 16'((w - 2) * (h - 2));
  endfunction

endpackage

// File: rtl/seq_addr_gen.sv
// Raster address counter for the pixel RAM. Counts 0..COUNT-1 on enable,
// wraps back to 0 after the last address, and can be cleared explicitly.
// last flags that the current address is the final pixel of the frame.
module seq_addr_gen #(
  parameter int ADDR_W = 10,
  parameter int COUNT  = 784
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COUNT - 1);

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;

  // Next address: clear wins, otherwise advance (with wrap) on each issued read.
  always_comb begin
    addr_d = addr_q;
    if (clr) begin
      addr_d = '0;
    end else if (en) begin
      if (addr_q == LAST_ADDR) begin
        addr_d = '0;
      end else begin
        addr_d = addr_q + ADDR_W'(1);
      end
    end
  end

  // Address register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr = addr_q;
  assign last = (addr_q == LAST_ADDR);

endmodule

// File: rtl/conv_frame_sequencer.sv
// Frame-level controller for the 3x3 sliding-window generator.
// IDLE -> CLEAR (generator held in reset) -> STREAM (raster reads from the
// pixel RAM, suspended by stall) -> DRAIN (flush pixel register and generator
// latency) -> DONE (one-cycle done pulse) -> IDLE.
// Optional feature macro: CONV_SEQ_WIN_CHECK_EN enables the window counter and
// the end-of-frame count comparison; without it win_count and count_err are 0.
module conv_frame_sequencer
  import cnn_pkg::*;
#(
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28,
  parameter int ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_rd_data,
  output logic              win_rst_n,
  output logic              pixel_valid,
  output logic [PIX_W-1:0]  pixel_in,
  input  logic              win_valid,
  output logic [15:0]       win_count,
  output logic              count_err
);

  localparam int N_PIX = IMG_WIDTH * IMG_HEIGHT;

  seq_state_e        state_q;
  seq_state_e        state_d;
  logic [1:0]        cyc_q;
  logic [1:0]        cyc_d;
  logic              start_accept;
  logic              addr_last;
  logic              pixel_valid_q;
  logic              pixel_valid_d;
  logic [PIX_W-1:0]  pixel_in_q;
  logic [PIX_W-1:0]  pixel_in_d;

  // Next-state logic and the read strobe; CLEAR and DRAIN are timed by cyc_q.
  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q;
    mem_rd_en    = 1'b0;
    start_accept = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          start_accept = 1'b1;
          state_d      = ST_CLEAR;
          cyc_d        = 2'd0;
        end
      end
      ST_CLEAR: begin
        if (cyc_q == 2'(CLEAR_CYCLES - 1)) begin
          state_d = ST_STREAM;
          cyc_d   = 2'd0;
        end else begin
          cyc_d = cyc_q + 2'd1;
        end
      end
      ST_STREAM: begin
        mem_rd_en = ~stall;
        if (~stall && addr_last) begin
          state_d = ST_DRAIN;
          cyc_d   = 2'd0;
        end
      end
      ST_DRAIN: begin
        if (cyc_q == 2'(DRAIN_CYCLES - 1)) begin
          state_d = ST_DONE;
          cyc_d   = 2'd0;
        end else begin
          cyc_d = cyc_q + 2'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cyc_d   = 2'd0;
      end
    endcase
  end

  // FSM state and phase counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cyc_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
    end
  end

  // Raster address; cleared on start so an abandoned frame never leaks in.
  seq_addr_gen #(
    .ADDR_W (ADDR_W),
    .COUNT  (N_PIX)
  ) u_addr_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_accept),
    .en   (mem_rd_en),
    .addr (mem_addr),
    .last (addr_last)
  );

  // Pixel path: strobe follows the read by one cycle, data is captured
  // while the strobe is high and held otherwise.
  always_comb begin
    pixel_valid_d = mem_rd_en;
    pixel_in_d    = pixel_in_q;
    if (pixel_valid_q) begin
      pixel_in_d = mem_rd_data;
    end
  end

  // Pixel path registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_valid_q <= 1'b0;
      pixel_in_q    <= '0;
    end else begin
      pixel_valid_q <= pixel_valid_d;
      pixel_in_q    <= pixel_in_d;
    end
  end

  assign pixel_valid = pixel_valid_q;
  assign pixel_in    = pixel_in_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  // Generator is held in reset both by the system reset and during CLEAR.
  assign win_rst_n   = ~(rst | (state_q == ST_CLEAR));

`ifdef CONV_SEQ_WIN_CHECK_EN
  localparam logic [15:0] EXP_WINDOWS = expected_windows(IMG_WIDTH, IMG_HEIGHT);

  logic [15:0] win_count_q;
  logic [15:0] win_count_d;
  logic        count_err_q;
  logic        count_err_d;
  logic        count_phase;

  assign count_phase = (state_q == ST_STREAM) || (state_q == ST_DRAIN);

  // Saturating window counter; the verdict is latched as DONE is left.
  always_comb begin
    win_count_d = win_count_q;
    count_err_d = count_err_q;
    if (start_accept) begin
      win_count_d = 16'd0;
      count_err_d = 1'b0;
    end else begin
      if (win_valid && count_phase && (win_count_q != 16'hFFFF)) begin
        win_count_d = win_count_q + 16'd1;
      end
      if (state_q == ST_DONE) begin
        count_err_d = (win_count_q != EXP_WINDOWS);
      end
    end
  end

  // Window counter and error flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_count_q <= 16'd0;
      count_err_q <= 1'b0;
    end else begin
      win_count_q <= win_count_d;
      count_err_q <= count_err_d;
    end
  end

  assign win_count = win_count_q;
  assign count_err = count_err_q;
`else
  logic unused_win_valid;

  assign unused_win_valid = win_valid;
  assign win_count        = 16'd0;
  assign count_err        = 1'b0;
`endif

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Self-checking bench for conv_frame_sequencer (28x28 frame). A pixel RAM
// model and a window-generator model surround the DUT; each frame is checked
// against frame-level expectations (latency, address order, pixel stream,
// window count).
module tb_conv_frame_sequencer;

  localparam int W      = 28;
  localparam int H      = 28;
  localparam int ADDR_W = 10;
  localparam int N      = W * H;
  localparam int WINS   = (W - 2) * (H - 2);
`ifdef CONV_SEQ_WIN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              stall;
  logic              busy;
  logic              done;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rd_data = 8'd0;
  logic              win_rst_n;
  logic              pixel_valid;
  logic [7:0]        pixel_in;
  logic              win_valid = 1'b0;
  logic [15:0]       win_count;
  logic              count_err;

  int n_checks = 0;
  int n_errors = 0;
  int drop_idx = -1;

  logic [7:0] ram [0:(1<<ADDR_W)-1];

  always #5 clk = ~clk;

  conv_frame_sequencer #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stall       (stall),
    .busy        (busy),
    .done        (done),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .win_rst_n   (win_rst_n),
    .pixel_valid (pixel_valid),
    .pixel_in    (pixel_in),
    .win_valid   (win_valid),
    .win_count   (win_count),
    .count_err   (count_err)
  );

  // Synchronous pixel RAM: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= ram[mem_addr];
  end

  // Window generator model: pixel k sits at row k/W, column k%W; a window
  // completes for every pixel with row>=2 and col>=2, one cycle later.
  int gen_k = 0;
  int gen_w = 0;
  always @(posedge clk) begin
    if (!win_rst_n) begin
      gen_k     <= 0;
      gen_w     <= 0;
      win_valid <= 1'b0;
    end else if (pixel_valid) begin
      if ((gen_k / W) >= 2 && (gen_k % W) >= 2) begin
        win_valid <= (gen_w != drop_idx);
        gen_w     <= gen_w + 1;
      end else begin
        win_valid <= 1'b0;
      end
      gen_k <= gen_k + 1;
    end else begin
      win_valid <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},      busy, 0);
    check({tag, "_done"},      done, 0);
    check({tag, "_rd_en"},     mem_rd_en, 0);
    check({tag, "_addr"},      mem_addr, 0);
    check({tag, "_pv"},        pixel_valid, 0);
    check({tag, "_pix"},       pixel_in, 0);
    check({tag, "_win_rst_n"}, win_rst_n, 0);
    check({tag, "_win_count"}, win_count, 0);
    check({tag, "_count_err"}, count_err, 0);
  endtask

  // Drive start for the upcoming edge (DUT is in IDLE).
  task automatic begin_frame();
    @(posedge clk); #1;
    start = 1'b1;
  endtask

  // Runs one frame whose start is already being driven. Inputs are set 1
  // time unit after each rising edge, outputs are sampled on falling edges.
  task automatic run_frame(input string name, input bit hold_start, input bit spam_start,
                           input bit rand_stall, input int stall_at, input int stall_len,
                           input int drop, input int rst_at);
    int  cyc = 0;
    int  reads = 0;
    int  stalls_win = 0;
    int  stall_used = 0;
    int  done_cnt = 0;
    int  done_cyc = -1;
    int  busy_drop = 0;
    int  addr_err = 0;
    int  pix_err = 0;
    int  pix_k = 0;
    int  rd_stall = 0;
    int  wrst_err = 0;
    int  exp_win;
    bit  prev_pv = 1'b0;
    bit  finished = 1'b0;
    bit  aborted = 1'b0;
    drop_idx = drop;
    exp_win = WINS - ((drop >= 0 && drop < WINS) ? 1 : 0);
    while (!finished && !aborted && cyc < 3000) begin
      @(posedge clk); #1;
      if (stall_len > 0 && cyc >= 2 && int'(mem_addr) == stall_at && stall_used < stall_len) begin
        stall = 1'b1;
        stall_used++;
      end else if (rand_stall) begin
        stall = ($urandom_range(0, 5) == 0);
      end else begin
        stall = 1'b0;
      end
      if (stall && cyc >= 2 && reads < N) stalls_win++;
      if (hold_start) start = 1'b1;
      else if (spam_start && !done && done_cnt == 0 && cyc >= 2) start = 1'($urandom_range(0, 1));
      else start = 1'b0;
      if (rst_at >= 0 && cyc >= 2 && int'(mem_addr) == rst_at) begin
        rst   = 1'b1;
        stall = 1'b0;
        start = 1'b0;
        #1;
        check_reset_outputs({name, "_midrst"});
        aborted = 1'b1;
      end else begin
        @(negedge clk);
        if (mem_rd_en) begin
          if (int'(mem_addr) != reads) addr_err++;
          if (stall) rd_stall++;
          reads++;
        end
        if (prev_pv) begin
          if (pix_k >= N || pixel_in !== ram[pix_k]) pix_err++;
          pix_k++;
        end
        prev_pv = pixel_valid;
        if (win_rst_n !== (cyc >= 2)) wrst_err++;
        if (cyc == 0) begin
          check({name, "_busy_rise"}, busy, 1);
          check({name, "_cnt_clr"}, win_count, 0);
          check({name, "_err_clr"}, count_err, 0);
        end
        if (done_cnt == 0 && !busy) busy_drop++;
        if (done) begin
          if (!busy) busy_drop++;
          done_cnt++;
          if (done_cnt == 1) done_cyc = cyc;
        end else if (done_cnt > 0) begin
          check({name, "_busy_fall"}, busy, 0);
          check({name, "_win_count"}, win_count, CHK ? exp_win : 0);
          check({name, "_count_err"}, count_err, CHK ? (exp_win != WINS) : 0);
          finished = 1'b1;
        end
        cyc++;
      end
    end
    if (aborted) begin
      repeat (3) begin
        @(posedge clk); #1;
        check({name, "_rst_hold_win_rst_n"}, win_rst_n, 0);
      end
      rst = 1'b0;
      @(negedge clk);
      check({name, "_post_rst_busy"}, busy, 0);
      check({name, "_post_rst_win_rst_n"}, win_rst_n, 1);
    end else if (!finished) begin
      check({name, "_done_timeout"}, 0, 1);
    end else begin
      check({name, "_done_latency"}, done_cyc, N + 4 + stalls_win);
      check({name, "_done_pulses"}, done_cnt, 1);
      check({name, "_reads"}, reads, N);
      check({name, "_addr_order"}, addr_err, 0);
      check({name, "_pixels"}, pix_err, 0);
      check({name, "_pixel_count"}, pix_k, N);
      check({name, "_rd_during_stall"}, rd_stall, 0);
      check({name, "_win_rst_n_clear"}, wrst_err, 0);
      check({name, "_busy_mid_frame"}, busy_drop, 0);
      $display("frame %s: done after %0d cycles (%0d stall cycles), win_count=%0d count_err=%0d",
               name, done_cyc, stalls_win, win_count, count_err);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 8'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_win_rst_n", win_rst_n, 1);

    begin_frame();
    run_frame("plain", 0, 0, 0, -1, 0, -1, -1);
    begin_frame();
    run_frame("stall100", 0, 0, 0, 100, 5, -1, -1);
    begin_frame();
    run_frame("spam_randstall", 0, 1, 1, -1, 0, -1, -1);
    begin_frame();
    run_frame("abort300", 0, 0, 0, -1, 0, -1, 300);
    begin_frame();
    run_frame("after_abort", 0, 0, 0, -1, 0, -1, -1);
    begin_frame();
    run_frame("drop", 0, 0, 0, -1, 0, $urandom_range(0, WINS - 1), -1);
    begin_frame();
    run_frame("after_drop", 0, 0, 1, -1, 0, -1, -1);
    begin_frame();
    run_frame("b2b_first", 1, 0, 0, -1, 0, -1, -1);
    run_frame("b2b_second", 0, 0, 0, -1, 0, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
